// File: rtl/mem_port_arbiter.sv
// Shares one single-beat memory port between instruction fetch and data load/store.
// Data wins conflicts until fetch has been passed over STARVE_MAX times; a hung access times out with err.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic [31:0]       if_rdata_o,
  output logic              if_err_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_ack_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ready_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int unsigned TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned SC_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  logic            owner_dm;
  logic [TO_W-1:0] to_cnt;
  logic [SC_W-1:0] starve_cnt;

  logic grant_dm_c;
  logic grant_if_c;
  logic timeout_c;

  // Data has priority unless fetch is waiting and has been starved to the limit.
  always_comb begin
    grant_dm_c = dm_req_i && (!if_req_i || (starve_cnt < SC_W'(STARVE_MAX)));
    grant_if_c = if_req_i && !grant_dm_c;
    timeout_c  = (to_cnt == TO_W'(TIMEOUT - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      owner_dm    <= 1'b0;
      to_cnt      <= '0;
      starve_cnt  <= '0;
      if_ack_o    <= 1'b0;
      if_rdata_o  <= '0;
      if_err_o    <= 1'b0;
      dm_ack_o    <= 1'b0;
      dm_rdata_o  <= '0;
      dm_err_o    <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_dm_c || grant_if_c) begin
            state     <= BUSY;
            mem_req_o <= 1'b1;
            to_cnt    <= '0;
            owner_dm  <= grant_dm_c;
          end
          if (grant_dm_c) begin
            mem_we_o    <= dm_we_i;
            mem_addr_o  <= dm_addr_i;
            mem_wdata_o <= dm_wdata_i;
            // Only a data grant that actually passes over a waiting fetch counts as starvation.
            if (!if_req_i) begin
              starve_cnt <= '0;
            end else if (starve_cnt != SC_W'(STARVE_MAX)) begin
              starve_cnt <= starve_cnt + SC_W'(1);
            end
          end else if (grant_if_c) begin
            mem_we_o    <= 1'b0;
            mem_addr_o  <= if_addr_i;
            mem_wdata_o <= '0;
            starve_cnt  <= '0;
          end
        end
        BUSY: begin
          // A ready arriving on the final timeout cycle still completes successfully.
          if (mem_ready_i || timeout_c) begin
            state     <= RESP;
            mem_req_o <= 1'b0;
            if (owner_dm) begin
              dm_ack_o   <= 1'b1;
              dm_err_o   <= !mem_ready_i;
              dm_rdata_o <= (mem_ready_i && !mem_we_o) ? mem_rdata_i : '0;
            end else begin
              if_ack_o   <= 1'b1;
              if_err_o   <= !mem_ready_i;
              if_rdata_o <= mem_ready_i ? mem_rdata_i[31:0] : '0;
            end
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        RESP: begin
          state      <= IDLE;
          if_ack_o   <= 1'b0;
          if_err_o   <= 1'b0;
          if_rdata_o <= '0;
          dm_ack_o   <= 1'b0;
          dm_err_o   <= 1'b0;
          dm_rdata_o <= '0;
        end
        default: begin
          state     <= IDLE;
          mem_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requesters push expected responses, a monitor checks acks,
// and a behavioural memory answers mem_req with random or forced latency.
module tb_mem_port_arbiter;

  localparam int          SMAX     = 4;
  localparam int          TMO      = 16;
  localparam int          HANG_BIT = 40;
  localparam logic [63:0] IF_BASE  = 64'h0000_0000_1000_0000;

  typedef struct packed {
    logic [63:0] rdata;
    logic        err;
    logic        hang;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [63:0] if_addr = '0;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [63:0] dm_addr = '0;
  logic [63:0] dm_wdata = '0;
  logic        dm_ack;
  logic [63:0] dm_rdata;
  logic        dm_err;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_ready = 1'b0;
  logic [63:0] mem_rdata = '0;

  exp_t        if_q[$];
  exp_t        dm_q[$];
  exp_t        mon_e;
  bit          grant_log[$];
  logic [63:0] ref_mem[logic [63:0]];
  logic [63:0] mem_model[logic [63:0]];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ready_cyc = -100;
  int last_req_len = 0;
  int fixed_lat = -1;
  bit last_we = 1'b0;

  mem_port_arbiter #(
    .ADDR_W(64), .DATA_W(64), .STARVE_MAX(SMAX), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_ack_o(if_ack), .if_rdata_o(if_rdata), .if_err_o(if_err),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
    .dm_ack_o(dm_ack), .dm_rdata_o(dm_rdata), .dm_err_o(dm_err),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_ready_i(mem_ready), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, expv, cyc);
    end
  endfunction

  function automatic logic [63:0] init_val(input logic [63:0] a);
    return {a[31:0] ^ 32'hA5A5_0000, ~a[31:0]};
  endfunction

  function automatic logic [63:0] ref_rd(input logic [63:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic logic [63:0] mem_rd(input logic [63:0] a);
    return mem_model.exists(a) ? mem_model[a] : init_val(a);
  endfunction

  function automatic bit all_out_zero();
    return ({if_ack, if_rdata, if_err, dm_ack, dm_rdata, dm_err,
             mem_req, mem_we, mem_addr, mem_wdata} == '0);
  endfunction

  // Behavioural memory: answers each request once after a chosen delay; hang addresses never answer.
  initial begin
    bit busy_seen;
    int wcnt, dly, req_len;
    busy_seen = 1'b0; wcnt = 0; dly = 0; req_len = 0;
    forever begin
      @(posedge clk); #1;
      mem_ready = 1'b0;
      if (!rst) begin
        busy_seen = 1'b0;
      end else if (mem_req) begin
        if (!busy_seen) begin
          busy_seen = 1'b1;
          wcnt = 0;
          req_len = 0;
          if (fixed_lat >= 0) dly = fixed_lat;
          else dly = ($urandom_range(0, 7) == 0) ? TMO - 1 : int'($urandom_range(0, 4));
        end
        req_len++;
        if (!mem_addr[HANG_BIT] && wcnt == dly) begin
          mem_ready = 1'b1;
          ready_cyc = cyc;
          last_we = mem_we;
          if (mem_addr[28]) chk("fetch_mem_we", 64'(mem_we), 64'd0);
          if (mem_we) begin
            mem_model[mem_addr] = mem_wdata;
            mem_rdata = {$urandom, $urandom};
          end else begin
            mem_rdata = mem_rd(mem_addr);
          end
        end
        wcnt++;
      end else begin
        if (busy_seen) begin
          last_req_len = req_len;
          busy_seen = 1'b0;
        end
        if ($urandom_range(0, 7) == 0) begin
          mem_ready = 1'b1;
          mem_rdata = {$urandom, $urandom};
        end
      end
    end
  end

  // Monitor: pops the owner's expectation on every ack.
  always @(negedge clk) begin
    if (rst) begin
      chk("err_without_ack", 64'((if_err && !if_ack) || (dm_err && !dm_ack)), 64'd0);
      if (if_ack || dm_ack) chk("ack_exclusive", 64'(if_ack && dm_ack), 64'd0);
      if (if_ack) begin
        grant_log.push_back(1'b0);
        chk("if_ack_expected", 64'(if_q.size() != 0), 64'd1);
        if (if_q.size() != 0) begin
          mon_e = if_q.pop_front();
          chk("if_rdata", 64'(if_rdata), mon_e.rdata);
          chk("if_err", 64'(if_err), 64'(mon_e.err));
          if (mon_e.hang) chk("if_timeout_len", 64'(last_req_len), 64'(TMO));
          else chk("if_ack_latency", 64'(cyc - ready_cyc), 64'd1);
        end
      end
      if (dm_ack) begin
        grant_log.push_back(1'b1);
        chk("dm_ack_expected", 64'(dm_q.size() != 0), 64'd1);
        if (dm_q.size() != 0) begin
          mon_e = dm_q.pop_front();
          chk("dm_rdata", dm_rdata, mon_e.rdata);
          chk("dm_err", 64'(dm_err), 64'(mon_e.err));
          if (mon_e.hang) chk("dm_timeout_len", 64'(last_req_len), 64'(TMO));
          else chk("dm_ack_latency", 64'(cyc - ready_cyc), 64'd1);
        end
      end
    end
  end

  task automatic wait_ack(input bit is_dm, output int ack_cyc);
    int n = 0;
    ack_cyc = -1;
    while (n < 200) begin
      @(negedge clk);
      if (is_dm ? dm_ack : if_ack) begin
        ack_cyc = cyc;
        break;
      end
      n++;
    end
    chk(is_dm ? "dm_ack_wait" : "if_ack_wait", 64'(ack_cyc >= 0), 64'd1);
  endtask

  task automatic do_if(input logic [63:0] a, output int iss_cyc, output int ack_cyc);
    exp_t e;
    logic [63:0] v;
    v = ref_rd(a);
    e.hang = a[HANG_BIT];
    e.err = a[HANG_BIT];
    e.rdata = a[HANG_BIT] ? 64'd0 : {32'd0, v[31:0]};
    if_q.push_back(e);
    if_req = 1'b1;
    if_addr = a;
    iss_cyc = cyc;
    wait_ack(1'b0, ack_cyc);
    @(posedge clk); #1;
    if_req = 1'b0;
    if_addr = {$urandom, $urandom};
  endtask

  task automatic do_dm(input logic we, input logic [63:0] a, input logic [63:0] wd,
                       output int iss_cyc, output int ack_cyc);
    exp_t e;
    e.hang = a[HANG_BIT];
    e.err = a[HANG_BIT];
    e.rdata = (a[HANG_BIT] || we) ? 64'd0 : ref_rd(a);
    if (we && !a[HANG_BIT]) ref_mem[a] = wd;
    dm_q.push_back(e);
    dm_req = 1'b1;
    dm_we = we;
    dm_addr = a;
    dm_wdata = wd;
    iss_cyc = cyc;
    wait_ack(1'b1, ack_cyc);
    @(posedge clk); #1;
    dm_req = 1'b0;
    dm_addr = {$urandom, $urandom};
    dm_wdata = {$urandom, $urandom};
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int ic, ac, acks;
    bit exp_seq[$];
    int pi, pd, st;
    logic [63:0] hang_a;

    repeat (3) @(posedge clk); #1;
    chk("reset_outputs", 64'(all_out_zero()), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;

    // Fetch only, memory answers next cycle.
    ref_mem[64'h40] = 64'h0000_0000_0050_0093;
    mem_model[64'h40] = 64'h0000_0000_0050_0093;
    fixed_lat = 0;
    do_if(64'h40, ic, ac);
    chk("t1_if_ack_cycle", 64'(ac - ic), 64'd2);
    fixed_lat = -1;

    // Store then load.
    do_dm(1'b1, 64'h10, 64'h0000_0000_DEAD_BEEF, ic, ac);
    chk("t2_store_mem_we", 64'(last_we), 64'd1);
    do_dm(1'b0, 64'h10, 64'd0, ic, ac);

    // Continuous conflict: grant order follows the starvation rule.
    grant_log.delete();
    fork
      begin
        int i1, i2;
        for (int k = 0; k < 2; k++) do_if(IF_BASE + 64'(k * 4), i1, i2);
      end
      begin
        int d1, d2;
        for (int k = 0; k < 8; k++) do_dm(1'b0, 64'(k * 8), 64'd0, d1, d2);
      end
    join
    pi = 2; pd = 8; st = 0;
    while (pi > 0 || pd > 0) begin
      if (pd > 0 && (pi == 0 || st < SMAX)) begin
        exp_seq.push_back(1'b1);
        st = (pi > 0) ? ((st < SMAX) ? st + 1 : st) : 0;
        pd--;
      end else begin
        exp_seq.push_back(1'b0);
        st = 0;
        pi--;
      end
    end
    chk("t3_grant_count", 64'(grant_log.size()), 64'(exp_seq.size()));
    for (int k = 0; k < exp_seq.size(); k++)
      if (k < grant_log.size()) chk($sformatf("t3_grant%0d", k), 64'(grant_log[k]), 64'(exp_seq[k]));

    // Timeouts on load and store, then normal accesses.
    hang_a = 64'h20;
    hang_a[HANG_BIT] = 1'b1;
    do_dm(1'b0, hang_a, 64'd0, ic, ac);
    chk("t4_timeout_ack_cycle", 64'(ac - ic), 64'(TMO + 1));
    do_dm(1'b0, 64'h20, 64'd0, ic, ac);
    hang_a = 64'h28;
    hang_a[HANG_BIT] = 1'b1;
    do_dm(1'b1, hang_a, 64'h1234_5678_9ABC_DEF0, ic, ac);
    do_dm(1'b0, 64'h28, 64'd0, ic, ac);

    // Reset while BUSY abandons the access.
    fixed_lat = 10;
    if_req = 1'b1;
    if_addr = IF_BASE + 64'h100;
    repeat (3) @(posedge clk); #1;
    chk("t5_busy_before_reset", 64'(mem_req), 64'd1);
    #2;
    rst = 1'b0;
    if_req = 1'b0;
    #1;
    chk("t5_reset_outputs", 64'(all_out_zero()), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    acks = 0;
    repeat (20) begin
      @(negedge clk);
      if (if_ack || dm_ack) acks++;
    end
    chk("t5_no_ack_after_reset", 64'(acks), 64'd0);
    @(posedge clk); #1;
    fixed_lat = -1;
    do_if(IF_BASE + 64'h100, ic, ac);

    // Late ready on the 4th BUSY cycle, and ready on the final timeout cycle.
    fixed_lat = 3;
    do_if(IF_BASE + 64'h80, ic, ac);
    chk("t6_late_ack_cycle", 64'(ac - ic), 64'd5);
    fixed_lat = TMO - 1;
    do_dm(1'b0, 64'h30, 64'd0, ic, ac);
    chk("ready_on_timeout_cycle", 64'(ac - ic), 64'(TMO + 1));
    fixed_lat = -1;

    // Random traffic on both ports with occasional hangs.
    fork
      begin
        int i1, i2;
        logic [63:0] a;
        for (int k = 0; k < 30; k++) begin
          a = IF_BASE + 64'($urandom_range(0, 255) * 4);
          if ($urandom_range(0, 19) == 0) a[HANG_BIT] = 1'b1;
          do_if(a, i1, i2);
          repeat ($urandom_range(0, 3)) @(posedge clk);
        end
      end
      begin
        int d1, d2;
        logic [63:0] a;
        for (int k = 0; k < 40; k++) begin
          a = 64'($urandom_range(0, 15) * 8);
          if ($urandom_range(0, 11) == 0) a[HANG_BIT] = 1'b1;
          do_dm(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, d1, d2);
          repeat ($urandom_range(0, 3)) @(posedge clk);
        end
      end
    join

    repeat (5) @(posedge clk);
    chk("if_queue_drained", 64'(if_q.size()), 64'd0);
    chk("dm_queue_drained", 64'(dm_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
